// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer sitting behind uart_rx.
// Captures every byte strobed by rx_dv into a circular FIFO and hands the bytes
// to the host in arrival order. It reports the fill level and almost-full, and
// it keeps a sticky overrun flag for bytes dropped while full.
//
// Ports:
//   rx_clk       in   clock shared with uart_rx
//   rx_rst_n     in   synchronous active-low reset
//   rx_dv        in   one-cycle strobe, rx_byte valid
//   rx_byte[7:0] in   received byte
//   rd_en        in   read request
//   rd_data[7:0] out  registered read data
//   rd_valid     out  one-cycle pulse qualifying rd_data
//   empty        out  count == 0
//   full         out  count == DEPTH
//   almost_full  out  count >= AF_LEVEL
//   count[AW:0]  out  bytes stored, 0..DEPTH
//   overrun      out  sticky: at least one byte dropped
//   ovr_clr      in   clears overrun (a same-cycle overrun wins)
module uart_rx_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst_n,
  input  logic                     rx_dv,
  input  logic [7:0]               rx_byte,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovr_q, ovr_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic          rd_acc;
  logic          wr_acc;

  // Reads only ever see bytes already stored, so a write and read arriving
  // together at count==0 store the byte and ignore the read (no fall-through).
  // At full, an accepted read frees the slot the same-cycle write lands in.
  always_comb begin
    rd_acc = rd_en && !empty_q;
    wr_acc = rx_dv && (!full_q || rd_acc);
  end

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (wr_acc) begin
      wp_d = wp_q + AW'(1);
    end
    if (rd_acc) begin
      rp_d      = rp_q + AW'(1);
      rd_data_d = mem_q[rp_q];
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CW'(1);
    end
    // Flags are registered from the next count so they track count exactly.
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    af_d    = (count_d >= CW'(AF_LEVEL));
    // Set has priority over clear.
    ovr_d   = (ovr_q && !ovr_clr) || (rx_dv && !wr_acc);
  end

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      ovr_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      af_q       <= af_d;
      ovr_q      <= ovr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage carries no reset; the reset pointers make old contents unreachable.
  always_ff @(posedge rx_clk) begin
    if (rx_rst_n && wr_acc) begin
      mem_q[wp_q] <= rx_byte;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DEPTH=16,
// AF_LEVEL=12). Inputs change 1 time unit after the rising edge and outputs
// are sampled there as well.
module tb_uart_rx_fifo;

  logic       rx_clk;
  logic       rx_rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overrun;
  logic       ovr_clr;

  int pass_cnt;
  int total_cnt;

  uart_rx_fifo #(
    .DEPTH    (16),
    .AF_LEVEL (12)
  ) dut (
    .rx_clk      (rx_clk),
    .rx_rst_n    (rx_rst_n),
    .rx_dv       (rx_dv),
    .rx_byte     (rx_byte),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
  endtask

  task automatic test_reset();
    rx_rst_n = 1'b0;
    tick();
    tick();
    total_cnt++;
    if ({count, empty, full, almost_full, overrun, rd_valid, rd_data} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b af=%b ov=%b rv=%b rd=%h, want cnt=0 e=1 f=0 af=0 ov=0 rv=0 rd=00",
               count, empty, full, almost_full, overrun, rd_valid, rd_data);
    else pass_cnt++;
    rx_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp [3];
    exp[0] = 8'hE3; exp[1] = 8'hBD; exp[2] = 8'h5A;
    for (int i = 0; i < 3; i++) wr_byte(exp[i]);
    total_cnt++;
    if (count !== 5'd3 || empty !== 1'b0)
      $display("FAIL basic_fill: got cnt=%0d e=%b, want cnt=3 e=0", count, empty);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      total_cnt++;
      if (rd_valid !== 1'b1 || rd_data !== exp[i])
        $display("FAIL basic_read%0d: got rv=%b rd=%h, want rv=1 rd=%h", i, rd_valid, rd_data, exp[i]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (rd_valid !== 1'b0)
        $display("FAIL basic_rv_pulse%0d: got rv=%b, want 0", i, rd_valid);
      else pass_cnt++;
    end
    total_cnt++;
    if (count !== 5'd0 || empty !== 1'b1)
      $display("FAIL basic_drained: got cnt=%0d e=%b, want cnt=0 e=1", count, empty);
    else pass_cnt++;
  endtask

  task automatic test_full_overrun();
    logic exp_af;
    for (int i = 0; i < 16; i++) begin
      wr_byte(8'(i));
      exp_af = ((i + 1) >= 12);
      total_cnt++;
      if (count !== 5'(i + 1) || almost_full !== exp_af || full !== (i == 15))
        $display("FAIL fill_w%0d: got cnt=%0d af=%b f=%b, want cnt=%0d af=%b f=%b",
                 i, count, almost_full, full, i + 1, exp_af, (i == 15));
      else pass_cnt++;
    end
    wr_byte(8'hAA);
    total_cnt++;
    if (overrun !== 1'b1 || count !== 5'd16 || full !== 1'b1)
      $display("FAIL overrun_set: got ov=%b cnt=%0d f=%b, want ov=1 cnt=16 f=1", overrun, count, full);
    else pass_cnt++;
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      total_cnt++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i))
        $display("FAIL drain_r%0d: got rv=%b rd=%h, want rv=1 rd=%h", i, rd_valid, rd_data, 8'(i));
      else pass_cnt++;
    end
    tick();
    rd_en = 1'b0;
    total_cnt++;
    if (rd_valid !== 1'b0 || empty !== 1'b1 || rd_data !== 8'h0F)
      $display("FAIL drain_end: got rv=%b e=%b rd=%h, want rv=0 e=1 rd=0f", rd_valid, empty, rd_data);
    else pass_cnt++;
    total_cnt++;
    if (overrun !== 1'b1)
      $display("FAIL overrun_sticky: got ov=%b, want 1", overrun);
    else pass_cnt++;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    total_cnt++;
    if (overrun !== 1'b0)
      $display("FAIL overrun_clear: got ov=%b, want 0", overrun);
    else pass_cnt++;
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 16; i++) wr_byte(8'h80 + 8'(i));
    rx_dv   = 1'b1;
    rx_byte = 8'h77;
    rd_en   = 1'b1;
    tick();
    rx_dv   = 1'b0;
    rd_en   = 1'b0;
    total_cnt++;
    if (overrun !== 1'b0 || count !== 5'd16 || full !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 8'h80)
      $display("FAIL full_simul: got ov=%b cnt=%0d f=%b rv=%b rd=%h, want ov=0 cnt=16 f=1 rv=1 rd=80",
               overrun, count, full, rd_valid, rd_data);
    else pass_cnt++;
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      total_cnt++;
      if (rd_valid !== 1'b1 || rd_data !== ((i == 16) ? 8'h77 : 8'h80 + 8'(i)))
        $display("FAIL full_simul_r%0d: got rv=%b rd=%h, want rv=1 rd=%h",
                 i, rd_valid, rd_data, (i == 16) ? 8'h77 : 8'h80 + 8'(i));
      else pass_cnt++;
    end
    rd_en = 1'b0;
    tick();
    total_cnt++;
    if (empty !== 1'b1 || rd_valid !== 1'b0)
      $display("FAIL full_simul_end: got e=%b rv=%b, want e=1 rv=0", empty, rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_interleave();
    logic [7:0] q [$];
    logic [7:0] exp;
    int wr_n;
    int cyc;
    logic do_wr, do_rd, rd_acc;
    wr_n = 0;
    cyc  = 0;
    while ((wr_n < 40 || q.size() > 0) && cyc < 600) begin
      do_wr  = (wr_n < 40) && ((cyc % 3) != 2);
      do_rd  = (((cyc * 5) % 7) < 3) || (wr_n >= 40);
      rd_acc = do_rd && (q.size() > 0);
      if (do_wr && q.size() >= 16 && !rd_acc) do_wr = 1'b0;
      rx_dv   = do_wr;
      rx_byte = 8'(wr_n * 37 + 5);
      rd_en   = do_rd;
      tick();
      if (rd_acc) begin
        exp = q.pop_front();
        total_cnt++;
        if (rd_valid !== 1'b1 || rd_data !== exp)
          $display("FAIL ilv_read_c%0d: got rv=%b rd=%h, want rv=1 rd=%h", cyc, rd_valid, rd_data, exp);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (rd_valid !== 1'b0)
          $display("FAIL ilv_idle_c%0d: got rv=%b, want 0", cyc, rd_valid);
        else pass_cnt++;
      end
      if (do_wr) begin
        q.push_back(rx_byte);
        wr_n++;
      end
      total_cnt++;
      if (count !== 5'(q.size()))
        $display("FAIL ilv_count_c%0d: got cnt=%0d, want %0d", cyc, count, q.size());
      else pass_cnt++;
      cyc++;
    end
    rx_dv = 1'b0;
    rd_en = 1'b0;
    total_cnt++;
    if (cyc >= 600 || wr_n != 40)
      $display("FAIL ilv_timeout: got cyc=%0d written=%0d, want cyc<600 written=40", cyc, wr_n);
    else pass_cnt++;
    total_cnt++;
    if (overrun !== 1'b0 || empty !== 1'b1)
      $display("FAIL ilv_end: got ov=%b e=%b, want ov=0 e=1", overrun, empty);
    else pass_cnt++;
  endtask

  task automatic test_empty_read();
    logic [7:0] prev;
    prev  = rd_data;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total_cnt++;
    if (rd_valid !== 1'b0 || rd_data !== prev || count !== 5'd0)
      $display("FAIL empty_read: got rv=%b rd=%h cnt=%0d, want rv=0 rd=%h cnt=0", rd_valid, rd_data, count, prev);
    else pass_cnt++;
    rx_dv   = 1'b1;
    rx_byte = 8'h11;
    rd_en   = 1'b1;
    tick();
    rx_dv   = 1'b0;
    rd_en   = 1'b0;
    total_cnt++;
    if (count !== 5'd1 || rd_valid !== 1'b0 || empty !== 1'b0)
      $display("FAIL no_fallthrough: got cnt=%0d rv=%b e=%b, want cnt=1 rv=0 e=0", count, rd_valid, empty);
    else pass_cnt++;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total_cnt++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h11)
      $display("FAIL empty_then_read: got rv=%b rd=%h, want rv=1 rd=11", rd_valid, rd_data);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 17; i++) wr_byte(8'hC0 + 8'(i));
    rd_en = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    rd_en = 1'b0;
    total_cnt++;
    if (count !== 5'd5 || overrun !== 1'b1 || rd_data !== 8'hCA)
      $display("FAIL pre_reset: got cnt=%0d ov=%b rd=%h, want cnt=5 ov=1 rd=ca", count, overrun, rd_data);
    else pass_cnt++;
    rx_rst_n = 1'b0;
    rx_dv    = 1'b1;
    rx_byte  = 8'h99;
    rd_en    = 1'b1;
    tick();
    rx_rst_n = 1'b1;
    rx_dv    = 1'b0;
    rd_en    = 1'b0;
    total_cnt++;
    if ({count, empty, full, almost_full, overrun, rd_valid, rd_data} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00})
      $display("FAIL mid_reset: got cnt=%0d e=%b f=%b af=%b ov=%b rv=%b rd=%h, want cnt=0 e=1 f=0 af=0 ov=0 rv=0 rd=00",
               count, empty, full, almost_full, overrun, rd_valid, rd_data);
    else pass_cnt++;
    wr_byte(8'h3C);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total_cnt++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C || count !== 5'd0)
      $display("FAIL post_reset_read: got rv=%b rd=%h cnt=%0d, want rv=1 rd=3c cnt=0", rd_valid, rd_data, count);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) wr_byte(8'(i));
    ovr_clr = 1'b1;
    wr_byte(8'hEE);
    ovr_clr = 1'b0;
    total_cnt++;
    if (overrun !== 1'b1 || count !== 5'd16)
      $display("FAIL clr_vs_set: got ov=%b cnt=%0d, want ov=1 cnt=16", overrun, count);
    else pass_cnt++;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    total_cnt++;
    if (overrun !== 1'b0)
      $display("FAIL clr_alone: got ov=%b, want 0", overrun);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rx_rst_n  = 1'b0;
    rx_dv     = 1'b0;
    rx_byte   = 8'h00;
    rd_en     = 1'b0;
    ovr_clr   = 1'b0;
    test_reset();
    test_basic();
    test_full_overrun();
    test_full_simul();
    test_interleave();
    test_empty_read();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of `uart_rx`. It captures each byte that `uart_rx` completes and holds it in a circular FIFO until the host logic reads it. It reports fill level and almost-full, and flags bytes lost to overrun. It runs in the same clock domain as `uart_rx`.

## Interface

- `DEPTH`, 16 — number of byte entries; power of two, ≥ 2. Address width AW = log2(DEPTH).
- `AF_LEVEL`, 12 — `almost_full` asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.

Ports:

- `rx_clk` in 1 — single clock, same clock as `uart_rx`.
- `rx_rst_n` in 1 — reset; synchronous, active-low.
- `rx_dv` in 1 — one-cycle strobe from `uart_rx`: `rx_byte` is valid this cycle.
- `rx_byte` in 8 — received byte from `uart_rx`.
- `rd_en` in 1 — read request from the consumer.
- `rd_data` out 8 — registered read data.
- `rd_valid` out 1 — one-cycle pulse; `rd_data` is valid this cycle.
- `empty` out 1 — count == 0.
- `full` out 1 — count == DEPTH.
- `almost_full` out 1 — count ≥ AF_LEVEL.
- `count` out AW+1 — number of stored bytes, range 0..DEPTH.
- `overrun` out 1 — sticky flag: at least one byte was dropped.
- `ovr_clr` in 1 — clears `overrun`.

## Operation

- Storage: DEPTH×8 array, write pointer `wp`, read pointer `rp`, each AW bits. Pointers wrap from DEPTH-1 to 0. `count` is a separate register.
- Write accepted when `rx_dv`=1 and either `full`=0 or a read is accepted in the same cycle. On accept: mem[wp] ← `rx_byte`, then wp+1.
- Read accepted when `rd_en`=1 and `empty`=0. On accept: `rd_data` ← mem[rp], then rp+1, and `rd_valid`=1 on the following cycle.
- `rd_en` while empty is ignored: no pointer change, `rd_valid`=0, `rd_data` holds its previous value.
- No fall-through: a write and a read in the same cycle at count==0 stores the byte only. Count becomes 1 and the read is ignored.
- Write and read both accepted in the same cycle: count unchanged and both pointers advance. This applies at full too; the read frees the slot.
- Overrun: `rx_dv`=1 while `full`=1 with no accepted read → byte dropped, memory and pointers untouched, `overrun` ← 1.
- `overrun` stays set until `ovr_clr`. If `ovr_clr` and a new overrun occur in the same cycle, set wins and `overrun` stays 1.
- `empty`, `full` and `almost_full` are registered and derived from the next-state count. They always agree with `count` in the same cycle.
- Memory contents are not reset; only pointers and flags are reset.

## Timing

- All state changes on the rising edge of `rx_clk`.
- Reset values: wp=rp=0, `count`=0, `empty`=1, `full`=0, `almost_full`=0, `overrun`=0, `rd_valid`=0, `rd_data`=8'h00.
- Reset dominates every other input in the same cycle.
- Reset mid-operation discards all stored bytes; `rd_valid` is low from the next cycle.
- Write latency: `rx_dv` sampled at edge N → `count`/`empty` updated after edge N.
- Read latency: `rd_en` sampled at edge N → `rd_data`/`rd_valid` presented after edge N, for one cycle.
- Minimum byte-in to byte-out: 2 edges (write at N, `rd_en` at N+1, data after N+1).
- Back-to-back reads: `rd_en` held high delivers one byte per cycle until empty. `rd_valid` drops the cycle after the last byte.
- `rx_dv` may arrive every cycle; at the UART rate it arrives at most once per 10×CLKS_PER_BIT cycles.

## Test plan

- Reset, then write 8'hE3, 8'hBD, 8'h5A via `rx_dv` pulses → count=3, empty=0. Three `rd_en` pulses → `rd_valid` pulses with E3, BD, 5A in order, then empty=1, count=0.
- Write DEPTH bytes 0x00..0x0F → full=1, count=16, almost_full=1 from the 12th write. Then `rx_dv` with 8'hAA → overrun=1, count=16. Read all → 0x00..0x0F in order, 8'hAA absent.
- At full, `rx_dv` with 8'h77 and `rd_en` in the same cycle → overrun stays 0, count=16. The last byte read out after draining is 8'h77.
- Write/read 40 bytes with a random interleave, reads during writes included → output sequence matches input. Pointers wrap at least twice; no overrun.
- `rd_en` on empty → `rd_valid`=0, `rd_data` unchanged. Empty-cycle write 8'h11 with `rd_en`=1 in the same cycle → count=1, `rd_valid`=0, next read returns 8'h11.
- With 5 bytes stored and overrun=1, assert `rx_rst_n`=0 for one cycle alongside `rx_dv` and `rd_en` → all reset values hold after the edge. Subsequent write 8'h3C reads back as 8'h3C. `ovr_clr` coinciding with an overrun leaves overrun=1.
